// File: rtl/exp_align_scheduler_pkg.sv
// rtl/exp_align_scheduler_pkg.sv - shared widths, state encoding and shift saturation helper
package exp_align_scheduler_pkg;

   localparam int DEF_EXP_W   = 6;
   localparam int DEF_N_TAPS  = 9;
   localparam int DEF_SHIFT_W = 5;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_EMIT    = 1'b1
   } state_t;

   // Largest representable alignment shift for a given output width
   function automatic int sh_sat(input int shift_w);
      return (1 << shift_w) - 1;
   endfunction

endpackage

// File: rtl/exp_align_scheduler_sat.sv
// rtl/exp_align_scheduler_sat.sv - saturating exponent difference, zero for skipped taps
module exp_sat_sub
   import exp_align_scheduler_pkg::*;
#(
   parameter int EXP_W   = DEF_EXP_W,
   parameter int SHIFT_W = DEF_SHIFT_W
) (
   input  logic [EXP_W-1:0]   i_a,
   input  logic [EXP_W-1:0]   i_b,
   input  logic               i_skip,
   output logic [SHIFT_W-1:0] o_amt
);

   localparam int SAT = sh_sat(SHIFT_W);

   logic [EXP_W-1:0] w_diff;
   logic             w_sat;

   // i_a is the window max, so the difference never wraps
   assign w_diff = i_a - i_b;
   assign w_sat  = int'(w_diff) > SAT;

   always_comb begin
      o_amt = '0;
      if (!i_skip) begin
         o_amt = w_sat ? SHIFT_W'(SAT) : w_diff[SHIFT_W-1:0];
      end
   end

endmodule

// File: rtl/exp_align_scheduler.sv
// rtl/exp_align_scheduler.sv - serial max-exponent tracker and per-tap alignment shift streamer
module exp_align_scheduler
   import exp_align_scheduler_pkg::*;
#(
   parameter int EXP_W   = DEF_EXP_W,
   parameter int N_TAPS  = DEF_N_TAPS,
   parameter int SHIFT_W = DEF_SHIFT_W
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [EXP_W-1:0]   i_exp,
   input  logic               i_skip,
   output logic               o_max_valid,
   output logic [EXP_W-1:0]   o_max_exp,
   output logic               o_sh_valid,
   input  logic               i_sh_ready,
   output logic [SHIFT_W-1:0] o_sh_amt,
   output logic [3:0]         o_sh_idx,
   output logic               o_sh_skip,
   output logic               o_busy
);

   localparam int CNT_W = $clog2(N_TAPS);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_in_cnt;
   logic [CNT_W-1:0]   r_out_cnt;
   logic [EXP_W-1:0]   r_run_max;
   logic [EXP_W-1:0]   r_buf_exp [N_TAPS];
   logic [N_TAPS-1:0]  r_buf_skip;

   logic               w_emit;
   logic               w_in_fire;
   logic               w_sh_fire;
   logic               w_in_last;
   logic               w_out_last;
   logic [EXP_W-1:0]   w_tap_exp;
   logic [SHIFT_W-1:0] w_amt;

   assign w_emit     = (r_state == ST_EMIT);
   assign w_in_fire  = i_in_valid & ~w_emit;
   assign w_sh_fire  = i_sh_ready & w_emit;
   assign w_in_last  = (r_in_cnt == CNT_W'(N_TAPS - 1));
   assign w_out_last = (r_out_cnt == CNT_W'(N_TAPS - 1));
   assign w_tap_exp  = i_skip ? '0 : i_exp;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_COLLECT: if (w_in_fire && w_in_last)  w_state_nxt = ST_EMIT;
         ST_EMIT:    if (w_sh_fire && w_out_last) w_state_nxt = ST_COLLECT;
         default:    w_state_nxt = ST_COLLECT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_in_cnt   <= '0;
         r_out_cnt  <= '0;
         r_run_max  <= '0;
         r_buf_skip <= '0;
         for (int i = 0; i < N_TAPS; i++) begin
            r_buf_exp[i] <= '0;
         end
      end else begin
         if (w_in_fire) begin
            r_buf_exp[r_in_cnt]  <= w_tap_exp;
            r_buf_skip[r_in_cnt] <= i_skip;
            r_in_cnt             <= w_in_last ? '0 : r_in_cnt + 1'b1;
            // first tap of a window loads; later taps replace only on a strictly larger exponent
            if (r_in_cnt == '0 || w_tap_exp > r_run_max) begin
               r_run_max <= w_tap_exp;
            end
         end
         if (w_sh_fire) begin
            r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
         end
      end
   end

   exp_sat_sub #(
      .EXP_W   (EXP_W),
      .SHIFT_W (SHIFT_W)
   ) u_sat (
      .i_a    (r_run_max),
      .i_b    (r_buf_exp[r_out_cnt]),
      .i_skip (r_buf_skip[r_out_cnt]),
      .o_amt  (w_amt)
   );

   // beat fields read straight from buffer/counter, so they only move on an accepted beat
   assign o_in_ready  = ~w_emit;
   assign o_max_valid = w_emit;
   assign o_max_exp   = w_emit ? r_run_max : '0;
   assign o_sh_valid  = w_emit;
   assign o_sh_amt    = w_emit ? w_amt : '0;
   assign o_sh_idx    = w_emit ? 4'(r_out_cnt) : 4'd0;
   assign o_sh_skip   = w_emit & r_buf_skip[r_out_cnt];
   assign o_busy      = w_emit | (r_in_cnt != '0);

endmodule

// File: tb/tb_exp_align_scheduler.sv
// tb/tb_exp_align_scheduler.sv - directed self-checking bench for exp_align_scheduler
module tb_exp_align_scheduler;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_in_valid;
   logic       o_in_ready;
   logic [5:0] i_exp;
   logic       i_skip;
   logic       o_max_valid;
   logic [5:0] o_max_exp;
   logic       o_sh_valid;
   logic       i_sh_ready;
   logic [4:0] o_sh_amt;
   logic [3:0] o_sh_idx;
   logic       o_sh_skip;
   logic       o_busy;

   int n_vec = 0;
   int n_err = 0;

   int t_exp  [9];
   int t_skip [9];
   int t_amt  [9];

   always #5 i_clk = ~i_clk;

   exp_align_scheduler dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_exp       (i_exp),
      .i_skip      (i_skip),
      .o_max_valid (o_max_valid),
      .o_max_exp   (o_max_exp),
      .o_sh_valid  (o_sh_valid),
      .i_sh_ready  (i_sh_ready),
      .o_sh_amt    (o_sh_amt),
      .o_sh_idx    (o_sh_idx),
      .o_sh_skip   (o_sh_skip),
      .o_busy      (o_busy)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic tap(input int e, input int s);
      i_in_valid = 1'b1;
      i_exp      = 6'(e);
      i_skip     = s[0];
      chk("in_ready", int'(o_in_ready), 1);
      tick();
   endtask

   task automatic run_window(input int exp_max);
      for (int i = 0; i < 9; i++) tap(t_exp[i], t_skip[i]);
      i_in_valid = 1'b0;
      i_sh_ready = 1'b1;
      chk("max_valid", int'(o_max_valid), 1);
      chk("max_exp", int'(o_max_exp), exp_max);
      for (int i = 0; i < 9; i++) begin
         chk("sh_valid", int'(o_sh_valid), 1);
         chk("sh_idx", int'(o_sh_idx), i);
         chk("sh_amt", int'(o_sh_amt), t_amt[i]);
         chk("sh_skip", int'(o_sh_skip), t_skip[i]);
         chk("in_ready_emit", int'(o_in_ready), 0);
         tick();
      end
      i_sh_ready = 1'b0;
      chk("in_ready_after", int'(o_in_ready), 1);
      chk("sh_valid_after", int'(o_sh_valid), 0);
      chk("busy_after", int'(o_busy), 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_in_ready", int'(o_in_ready), 1);
      chk("rst_max_valid", int'(o_max_valid), 0);
      chk("rst_max_exp", int'(o_max_exp), 0);
      chk("rst_sh_valid", int'(o_sh_valid), 0);
      chk("rst_sh_amt", int'(o_sh_amt), 0);
      chk("rst_sh_idx", int'(o_sh_idx), 0);
      chk("rst_sh_skip", int'(o_sh_skip), 0);
      chk("rst_busy", int'(o_busy), 0);
   endtask

   initial begin
      int b;
      int cyc;
      int r;
      i_rst_n    = 1'b0;
      i_in_valid = 1'b0;
      i_exp      = '0;
      i_skip     = 1'b0;
      i_sh_ready = 1'b0;
      repeat (2) @(negedge i_clk);
      chk_reset_outputs();
      i_rst_n = 1'b1;
      tick();

      // reset in the middle of a window
      tap(3, 0); tap(10, 0); tap(7, 0); tap(10, 0);
      i_in_valid = 1'b0;
      chk("busy_mid", int'(o_busy), 1);
      i_rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // plain window, fresh after reset
      t_exp  = '{3, 10, 7, 10, 1, 2, 9, 4, 5};
      t_skip = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      t_amt  = '{7, 0, 3, 0, 9, 8, 1, 6, 5};
      run_window(10);

      // skipped taps carry a large exponent that must not win the max
      t_exp  = '{20, 31, 20, 20, 31, 20, 20, 20, 20};
      t_skip = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
      t_amt  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_window(20);

      // saturation: diff 38 clamps to 31
      t_exp  = '{40, 2, 2, 2, 2, 2, 2, 2, 2};
      t_skip = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      t_amt  = '{0, 31, 31, 31, 31, 31, 31, 31, 31};
      run_window(40);

      // random back-pressure, input valid held high through EMIT
      t_exp  = '{12, 5, 33, 17, 12, 40, 7, 1, 20};
      t_skip = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
      t_amt  = '{28, 31, 7, 23, 28, 0, 0, 31, 20};
      for (int i = 0; i < 9; i++) tap(t_exp[i], t_skip[i]);
      i_exp  = 6'd63;
      i_skip = 1'b0;
      b   = 0;
      cyc = 0;
      while (b < 9 && cyc < 200) begin
         r = int'($urandom_range(0, 1));
         i_sh_ready = r[0];
         chk("bp_sh_valid", int'(o_sh_valid), 1);
         chk("bp_sh_idx", int'(o_sh_idx), b);
         chk("bp_sh_amt", int'(o_sh_amt), t_amt[b]);
         chk("bp_sh_skip", int'(o_sh_skip), t_skip[b]);
         chk("bp_in_ready", int'(o_in_ready), 0);
         chk("bp_max_exp", int'(o_max_exp), 40);
         tick();
         if (r != 0) b++;
         cyc++;
      end
      chk("bp_beats_done", b, 9);
      i_in_valid = 1'b0;
      i_sh_ready = 1'b0;
      chk("bp_busy_after", int'(o_busy), 0);
      chk("bp_in_ready_after", int'(o_in_ready), 1);

      // all skipped, two windows back to back
      t_exp  = '{50, 9, 63, 1, 0, 30, 12, 44, 5};
      t_skip = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
      t_amt  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      run_window(0);
      run_window(0);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
